// File: rtl/layer_seq_pkg.sv
// Shared definitions for the layered systolic sequencer.
//   state_t        : sequencer FSM encoding (IDLE/RUN/DONE/ERR)
//   DEF_SENTINEL   : default end-of-layer marker in weight memory
//   slice_off()    : bit offset of element k in a packed per-layer bus
package layer_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [31:0] DEF_SENTINEL = 32'h7fffffff;

    function automatic int unsigned slice_off(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/layer_seq_ctrl_counter.sv
// layer_counter: address counter for a single layer.
// Ports:
//   clk, reset        clock / async active-high reset
//   en                layer is the running one; count this edge
//   clr               synchronous clear (accepted go)
//   hold_at_sentinel  freeze the count on the edge the sentinel is seen
//   rdata             weight word read at the current address
//   cnt               current address
//   hit_sentinel      rdata equals the sentinel word (combinational)
//   at_max            cnt has reached MAX_COUNT (combinational)
// The counter never wraps: it stops at MAX_COUNT.
module layer_counter
    import layer_seq_pkg::*;
#(
    parameter int unsigned           DATA_W    = 32,
    parameter int unsigned           CNT_W     = 10,
    parameter int unsigned           MAX_COUNT = 1023,
    parameter logic [DATA_W-1:0]     SENTINEL  = DATA_W'(DEF_SENTINEL)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic              hold_at_sentinel,
    input  logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  cnt,
    output logic              hit_sentinel,
    output logic              at_max
);

    assign hit_sentinel = (rdata == SENTINEL);
    assign at_max       = (cnt == CNT_W'(MAX_COUNT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !(hold_at_sentinel && hit_sentinel) && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: N-layer sequencer for the systolic inference datapath.
// Runs layers strictly in order; a layer ends when its weight stream returns
// SENTINEL, and overruns to ERR if its counter reaches MAX_COUNT first.
// Ports:
//   clk, reset     clock / async active-high reset
//   go             single-cycle start (accepted in IDLE, DONE, ERR)
//   rdata          per-layer weight words, layer k at [k*DATA_W +: DATA_W]
//   cnt            per-layer address counters, packed like rdata
//   layer_active   one-hot running layer while in RUN
//   layer_done     sticky per-layer sentinel-seen flags
//   busy/all_done/timeout_err  RUN / DONE / ERR indicators
//   cur_layer      running layer index, 0 outside RUN
//   cycle_count    RUN-cycle performance counter
// Build option: define LAYER_SEQ_PERF_EN to enable cycle_count; otherwise it
// is tied to zero.
module layer_seq_ctrl
    import layer_seq_pkg::*;
#(
    parameter int unsigned       NUM_LAYERS = 2,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       CNT_W      = 10,
    parameter int unsigned       MAX_COUNT  = 1023,
    parameter logic [DATA_W-1:0] SENTINEL   = DATA_W'(DEF_SENTINEL)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic [NUM_LAYERS*DATA_W-1:0] rdata,
    output logic [NUM_LAYERS*CNT_W-1:0]  cnt,
    output logic [NUM_LAYERS-1:0]        layer_active,
    output logic [NUM_LAYERS-1:0]        layer_done,
    output logic                         busy,
    output logic                         all_done,
    output logic                         timeout_err,
    output logic [2:0]                   cur_layer,
    output logic [31:0]                  cycle_count
);

    state_t                  state_q, state_d;
    logic [2:0]              cur_q, cur_d;
    logic [NUM_LAYERS-1:0]   done_q, done_d;
    logic [NUM_LAYERS-1:0]   hit, at_max;
    logic                    sel_hit, sel_max;
    logic                    start;

    genvar g;
    generate
        for (g = 0; g < NUM_LAYERS; g++) begin : g_layer
            layer_counter #(
                .DATA_W    (DATA_W),
                .CNT_W     (CNT_W),
                .MAX_COUNT (MAX_COUNT),
                .SENTINEL  (SENTINEL)
            ) u_cnt (
                .clk              (clk),
                .reset            (reset),
                .en               (layer_active[g]),
                .clr              (start),
                .hold_at_sentinel (1'b1),
                .rdata            (rdata[slice_off(g, DATA_W) +: DATA_W]),
                .cnt              (cnt[slice_off(g, CNT_W) +: CNT_W]),
                .hit_sentinel     (hit[g]),
                .at_max           (at_max[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        done_d  = done_q;
        start   = 1'b0;
        sel_hit = 1'b0;
        sel_max = 1'b0;
        // Only the running layer's rdata/limit matter; others are ignored.
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (cur_q == 3'(i)) begin
                sel_hit = hit[i];
                sel_max = at_max[i];
            end
        end
        case (state_q)
            RUN: begin
                // Sentinel outranks overrun, so a sentinel at MAX_COUNT completes.
                if (sel_hit) begin
                    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                        if (cur_q == 3'(i)) done_d[i] = 1'b1;
                    end
                    if (cur_q == 3'(NUM_LAYERS - 1)) begin
                        state_d = DONE;
                        cur_d   = '0;
                    end else begin
                        cur_d = cur_q + 3'd1;
                    end
                end else if (sel_max) begin
                    state_d = ERR;
                    cur_d   = '0;
                end
            end
            default: begin
                if (go) begin
                    start   = 1'b1;
                    state_d = RUN;
                    cur_d   = '0;
                    done_d  = '0;
                end
            end
        endcase
    end

    always_comb begin
        layer_active = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            layer_active[i] = (state_q == RUN) && (cur_q == 3'(i));
        end
    end

    assign layer_done  = done_q;
    assign busy        = (state_q == RUN);
    assign all_done    = (state_q == DONE);
    assign timeout_err = (state_q == ERR);
    assign cur_layer   = cur_q;

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (start) begin
            cyc_q <= '0;
        end else if ((state_q == RUN) && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl: a 2-layer default instance driven by a
// small weight-memory model, plus a 4-layer instance whose memory returns the
// sentinel everywhere.
module tb_layer_seq_ctrl;

    localparam logic [31:0] SENT = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic        go4 = 1'b0;

    logic [63:0]  rdata;
    logic [19:0]  cnt;
    logic [1:0]   layer_active, layer_done;
    logic         busy, all_done, timeout_err;
    logic [2:0]   cur_layer;
    logic [31:0]  cycle_count;

    logic [127:0] rdata4;
    logic [39:0]  cnt4;
    logic [3:0]   layer_active4, layer_done4;
    logic         busy4, all_done4, timeout_err4;
    logic [2:0]   cur_layer4;
    logic [31:0]  cycle_count4;

    // weight memory model: sentinel at a chosen address per layer
    logic [9:0] sent_at0 = 10'd800;
    logic [9:0] sent_at1 = 10'd40;
    logic       no_sent0 = 1'b0;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    always_comb begin
        rdata[31:0]  = (!no_sent0 && cnt[9:0] == sent_at0) ? SENT : {22'd0, cnt[9:0]};
        rdata[63:32] = (cnt[19:10] == sent_at1) ? SENT : {22'd0, cnt[19:10]};
    end

    assign rdata4 = {4{SENT}};

    layer_seq_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .rdata        (rdata),
        .cnt          (cnt),
        .layer_active (layer_active),
        .layer_done   (layer_done),
        .busy         (busy),
        .all_done     (all_done),
        .timeout_err  (timeout_err),
        .cur_layer    (cur_layer),
        .cycle_count  (cycle_count)
    );

    layer_seq_ctrl #(.NUM_LAYERS(4)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .go           (go4),
        .rdata        (rdata4),
        .cnt          (cnt4),
        .layer_active (layer_active4),
        .layer_done   (layer_done4),
        .busy         (busy4),
        .all_done     (all_done4),
        .timeout_err  (timeout_err4),
        .cur_layer    (cur_layer4),
        .cycle_count  (cycle_count4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick(1);
        go = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        chk("rst_cnt",    64'(cnt), 64'd0);
        chk("rst_status", {busy, all_done, timeout_err, cur_layer, layer_active, layer_done},
                          64'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("idle_busy", 64'(busy), 64'd0);

        // normal two-layer run: layer0 ends at 800, layer1 at 40
        pulse_go();
        chk("go_busy",   64'(busy), 64'd1);
        chk("go_active", 64'(layer_active), 64'b01);
        chk("go_cnt",    64'(cnt), 64'd0);
        tick(800);
        chk("l0_at800_cnt",    64'(cnt), {44'd0, 10'd0, 10'd800});
        chk("l0_at800_active", 64'(layer_active), 64'b01);
        tick(1);
        chk("handover_active", 64'(layer_active), 64'b10);
        chk("handover_done",   64'(layer_done), 64'b01);
        chk("handover_cnt",    64'(cnt), {44'd0, 10'd0, 10'd800});
        chk("handover_cur",    64'(cur_layer), 64'd1);
        tick(40);
        chk("l1_at40_busy", 64'(busy), 64'd1);
        tick(1);
        chk("done_status", {busy, all_done, timeout_err}, 64'b010);
        chk("done_cnt",    64'(cnt), {44'd0, 10'd40, 10'd800});
        chk("done_flags",  64'(layer_done), 64'b11);
        chk("done_active", 64'(layer_active), 64'd0);
        chk("done_cur",    64'(cur_layer), 64'd0);
`ifdef LAYER_SEQ_PERF_EN
        chk("perf_cycles", 64'(cycle_count), 64'd842);
        tick(3);
        chk("perf_hold",   64'(cycle_count), 64'd842);
`else
        chk("perf_off",    64'(cycle_count), 64'd0);
`endif

        // layer0 never returns the sentinel -> overrun
        no_sent0 = 1'b1;
        pulse_go();
        chk("restart_status", {busy, all_done, timeout_err}, 64'b100);
        chk("restart_cnt",    64'(cnt), 64'd0);
        chk("restart_done",   64'(layer_done), 64'd0);
        tick(100);
        chk("at100_cnt", 64'(cnt), 64'd100);
        pulse_go();
        chk("go_in_run_101", 64'(cnt), 64'd101);
        tick(1);
        chk("go_in_run_102", 64'(cnt), 64'd102);
        tick(1023 - 102);
        chk("at_max_busy", 64'(busy), 64'd1);
        chk("at_max_cnt",  64'(cnt), 64'd1023);
        tick(1);
        chk("err_status", {busy, all_done, timeout_err}, 64'b001);
        chk("err_cnt",    64'(cnt), 64'd1023);
        tick(3);
        chk("err_hold",   64'(cnt), 64'd1023);
        no_sent0 = 1'b0;
        sent_at0 = 10'd5;
        sent_at1 = 10'd40;
        pulse_go();
        chk("err_restart", {busy, all_done, timeout_err, 10'(cnt[9:0])}, {3'b100, 10'd0});

        // async reset in the middle of layer1
        tick(5);
        tick(1);
        chk("l1_started", 64'(cur_layer), 64'd1);
        tick(20);
        chk("l1_at20", 64'(cnt), {44'd0, 10'd20, 10'd5});
        #2 reset = 1'b1;
        #1;
        chk("async_rst_cnt",    64'(cnt), 64'd0);
        chk("async_rst_status", {busy, all_done, timeout_err, cur_layer, layer_active, layer_done},
                                64'd0);
        tick(1);
        reset = 1'b0;
        tick(5);
        chk("post_rst_idle", {busy, all_done, timeout_err, 20'(cnt)}, 64'd0);

        // sentinel coincides with MAX_COUNT: completion wins; layer1 ends at 0
        sent_at0 = 10'd1023;
        sent_at1 = 10'd0;
        pulse_go();
        tick(1023);
        chk("max_sent_cnt", 64'(cnt), 64'd1023);
        tick(1);
        chk("max_sent_next", {timeout_err, busy, cur_layer, layer_done}, {1'b0, 1'b1, 3'd1, 2'b01});
        tick(1);
        chk("max_sent_done", {all_done, timeout_err, 20'(cnt)}, {2'b10, 10'd0, 10'd1023});

        // 4-layer instance, sentinel at address 0 on every layer
        go4 = 1'b1;
        tick(1);
        go4 = 1'b0;
        chk("l4_go", {busy4, all_done4, layer_active4}, {2'b10, 4'b0001});
        tick(3);
        chk("l4_t3", {busy4, cur_layer4, layer_done4}, {1'b1, 3'd3, 4'b0111});
        tick(1);
        chk("l4_done", {all_done4, busy4, timeout_err4, layer_done4}, {3'b100, 4'b1111});
        chk("l4_cnt",  64'(cnt4), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layer_seq_ctrl.md
Name: layer_seq_ctrl

Overview:
Parametrised sequencer for the layered systolic inference datapath. It drives one weight-address counter per layer, runs the layers strictly in order, and ends each layer when that layer's weight stream returns the sentinel word. It replaces the fixed two-layer start/stop logic with an N-layer FSM that adds an explicit go/done handshake toward the PicoRV32 peripheral and a per-layer overrun timeout.

Parameters:
NUM_LAYERS, 2, number of sequential layers (1..8)
DATA_W, 32, width of each weight read-data word
CNT_W, 10, width of each layer address counter
MAX_COUNT, 1023, counter value that flags overrun if no sentinel has been seen
SENTINEL, 32'h7fffffff, end-of-layer marker in weight memory

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
go  in  1  single-cycle start request from the CPU peripheral
rdata  in  NUM_LAYERS*DATA_W  weight read data; layer k occupies bits [k*DATA_W +: DATA_W]
cnt  out  NUM_LAYERS*CNT_W  per-layer address counters, packed the same way as rdata
layer_active  out  NUM_LAYERS  high while layer k is counting (enables that systolic array)
layer_done  out  NUM_LAYERS  sticky, set when layer k has seen the sentinel
busy  out  1  high in RUN
all_done  out  1  high in DONE
timeout_err  out  1  high in ERR
cur_layer  out  3  index of the running layer; 0 outside RUN
cycle_count  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high. While reset is high: state=IDLE, all cnt=0, layer_active=0, layer_done=0, busy=0, all_done=0, timeout_err=0, cur_layer=0.
- FSM states: IDLE, RUN, DONE, ERR.
- IDLE: on go=1, clear all counters and layer_done, set cur_layer=0, enter RUN. layer_active[0] rises the cycle after go.
- RUN, layer k = cur_layer. Each posedge evaluates in this priority order:
  1. rdata[k]==SENTINEL: cnt[k] holds; layer_done[k]<=1. If k<NUM_LAYERS-1, cur_layer<=k+1, otherwise state<=DONE.
  2. cnt[k]==MAX_COUNT: state<=ERR; cnt[k] holds.
  3. Otherwise cnt[k]<=cnt[k]+1.
- A sentinel at the same edge as MAX_COUNT counts as normal completion, not an error.
- layer_active is combinational: one-hot at cur_layer while in RUN, all zero in any other state.
- Handover has zero dead cycles. Layer k+1 counts from 0 on the first edge after layer k's sentinel edge.
- Counters of finished layers hold their final value until the next accepted go. Counters of later layers stay at 0.
- go is ignored in RUN. In DONE or ERR, go restarts the sequence exactly as from IDLE. Status outputs clear on the edge that accepts go.
- Counters never wrap. Overrun is caught at MAX_COUNT, which must be at most 2^CNT_W-1.
- rdata is sampled only for the active layer. Sentinels on inactive layers have no effect.
- Reset asserted mid-RUN aborts immediately to the reset values above. No partial-state retention.

Optional Feature:
- Macro: LAYER_SEQ_PERF_EN.
- Defined: cycle_count clears on an accepted go, increments every cycle in RUN, and holds in DONE or ERR. It saturates at 32'hFFFFFFFF.
- Undefined: cycle_count is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package layer_seq_pkg holds the state enum (IDLE/RUN/DONE/ERR), the default SENTINEL constant, and a helper function for the packed-slice offset.
- Sub-module layer_counter: one CNT_W counter with inputs en, clr, hold_at_sentinel and outputs hit_sentinel, at_max. It is instantiated NUM_LAYERS times via generate.
- The FSM, cur_layer and the perf counter stay in the top module.

Test Plan:
- Reset with defaults: all outputs 0. Pulse go; layer0 rdata is non-sentinel until cnt0==800, where it reads SENTINEL -> cnt0 holds at 800, layer_done[0]=1, layer_active=2'b10 on the next cycle.
- Continue the run with layer1 sentinel at cnt1==40 -> all_done=1, busy=0, cnt={40,800}. With LAYER_SEQ_PERF_EN defined, cycle_count=842 (1 + 801 + 41 − 1 alignment checked against the RUN-cycle count).
- Layer0 never returns the sentinel -> at cnt0==1023 timeout_err=1, state ERR, cnt0 holds at 1023. A following go restarts with cnt0=0 and timeout_err=0.
- go pulsed during RUN at cnt0==100 -> ignored; the count continues 101, 102, …
- Reset asserted at cnt1==20 -> all outputs return to 0 asynchronously, without waiting for a clock edge. After release, the block stays in IDLE until go.
- NUM_LAYERS=4, sentinel present at cnt==0 for every layer -> each layer completes in one cycle, layer_done=4'b1111, and all_done is reached 4 cycles after go is accepted.
